write_master: RTL and testbench

WRITE_MASTER -- requirements
Module: write_master

---
 rtl/write_master.sv | 88 ++++++++
 tb/tb_write_master.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/write_master.sv
// write_master: Avalon-MM write master draining a show-ahead FIFO to consecutive word addresses.
module write_master #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iStart,
  input  logic [ADDR_W-1:0] iStartaddress,
  input  logic [31:0]       iLength,
  input  logic              iFifo_empty,
  input  logic [DATA_W-1:0] iFifo_data,
  output logic              oFifo_rdreq,
  output logic [ADDR_W-1:0] oAddress,
  output logic              oWrite,
  output logic [DATA_W-1:0] oWritedata,
  output logic [3:0]        oByteenable,
  input  logic              iWaitrequest,
  output logic              oBusy,
  output logic              oDone
);
  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [29:0] count_q, count_d;
  logic write_q, write_d, busy_q, busy_d, done_q, done_d;
  assign oFifo_rdreq = (state_q == FETCH) && !iFifo_empty;
  assign oAddress = addr_q;
  assign oWrite = write_q;
  assign oWritedata = data_q;
  assign oByteenable = 4'hF;
  assign oBusy = busy_q;
  assign oDone = done_q;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    data_d = data_q;
    count_d = count_q;
    write_d = write_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (iStart) begin
        addr_d = iStartaddress;
        count_d = iLength[31:2];
        busy_d = 1'b1;
        state_d = (iLength[31:2] != 30'd0) ? FETCH : DONE;
      end
      FETCH: if (!iFifo_empty) begin
        data_d = iFifo_data;
        write_d = 1'b1;
        state_d = WRITE;
      end
      WRITE: if (!iWaitrequest) begin
        write_d = 1'b0;
        addr_d = addr_q + ADDR_W'(4);
        count_d = count_q - 30'd1;
        state_d = (count_q == 30'd1) ? DONE : FETCH;
      end
      DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      count_q <= '0;
      write_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      data_q <= data_d;
      count_q <= count_d;
      write_q <= write_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_write_master.sv
// tb_write_master: randomized transfers against a queue-based model of addresses, data order and done timing.
module tb_write_master;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic iReset, iStart, iFifo_empty, iWaitrequest;
  logic [31:0] iStartaddress, iLength, iFifo_data;
  logic oFifo_rdreq, oWrite, oBusy, oDone;
  logic [31:0] oAddress, oWritedata;
  logic [3:0] oByteenable;
  write_master dut (
    .iClk(clk), .iReset(iReset), .iStart(iStart), .iStartaddress(iStartaddress),
    .iLength(iLength), .iFifo_empty(iFifo_empty), .iFifo_data(iFifo_data),
    .oFifo_rdreq(oFifo_rdreq), .oAddress(oAddress), .oWrite(oWrite),
    .oWritedata(oWritedata), .oByteenable(oByteenable), .iWaitrequest(iWaitrequest),
    .oBusy(oBusy), .oDone(oDone)
  );
  int total = 0, bad = 0;
  logic [31:0] fifo_q[$], exp_data[$], acc_addr[$], acc_data[$];
  int acc_len[$];
  int cyc = 0, pops, done_cnt, done_cyc, last_acc_cyc, start_cyc, viol, gap_writes, run_len;
  bit busy_at_done, prev_stall, pend_pop, gap_now, mid_start;
  logic [31:0] prev_addr, prev_data;
  int wait_pct = 0, gap_pct = 0, stall_idx = -1, stall_left = 0, gap_idx = -1, gap_left = 0;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic monitor();
    cyc++;
    if (iStart && !oBusy) start_cyc = cyc;
    if (oFifo_rdreq && (iFifo_empty || oWrite || !oBusy)) viol++;
    if (oByteenable !== 4'hF) viol++;
    if (prev_stall && (!oWrite || oAddress !== prev_addr || oWritedata !== prev_data)) viol++;
    if (gap_now && (oWrite || oFifo_rdreq)) gap_writes++;
    if (oWrite) run_len++;
    if (oWrite && !iWaitrequest) begin
      acc_addr.push_back(oAddress);
      acc_data.push_back(oWritedata);
      acc_len.push_back(run_len);
      run_len = 0;
      last_acc_cyc = cyc;
    end
    pend_pop = oFifo_rdreq;
    if (oFifo_rdreq) pops++;
    if (oDone) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = oBusy;
    end
    prev_stall = oWrite && iWaitrequest;
    prev_addr = oAddress;
    prev_data = oWritedata;
  endtask
  task automatic apply();
    if (pend_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
    pend_pop = 1'b0;
    iStart = 1'b0;
    gap_now = 1'b0;
    if (gap_left > 0 && acc_addr.size() == gap_idx) begin
      gap_now = 1'b1;
      gap_left--;
    end
    iFifo_empty = gap_now || fifo_q.size() == 0 || ($urandom_range(99) < gap_pct);
    iFifo_data = fifo_q.size() > 0 ? fifo_q[0] : $urandom;
    if (oWrite && acc_addr.size() == stall_idx && stall_left > 0) begin
      iWaitrequest = 1'b1;
      stall_left--;
    end else iWaitrequest = $urandom_range(99) < wait_pct;
    if (mid_start && cyc == start_cyc + 3) begin
      iStart = 1'b1;
      iStartaddress = 32'h5555_0000;
      iLength = 32'd40;
    end
  endtask
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    apply();
  endtask
  task automatic clear_stats();
    acc_addr.delete();
    acc_data.delete();
    acc_len.delete();
    exp_data.delete();
    fifo_q.delete();
    pops = 0; done_cnt = 0; viol = 0; gap_writes = 0; run_len = 0;
    done_cyc = 0; last_acc_cyc = 0; prev_stall = 1'b0; busy_at_done = 1'b1;
  endtask
  task automatic load_fifo(int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      w = $urandom;
      fifo_q.push_back(w);
      exp_data.push_back(w);
    end
    iFifo_empty = fifo_q.size() == 0;
    iFifo_data = fifo_q.size() > 0 ? fifo_q[0] : 32'h0;
  endtask
  task automatic run_xfer(logic [31:0] addr, logic [31:0] len, int extra);
    int nw;
    nw = int'(len >> 2);
    clear_stats();
    load_fifo(nw + extra);
    iStart = 1'b1;
    iStartaddress = addr;
    iLength = len;
    for (int k = 0; k < 3000 && done_cnt == 0; k++) tick();
    repeat (3) tick();
    chk("done_pulses", done_cnt, 1);
    chk("busy_at_done", busy_at_done, 0);
    chk("word_count", acc_addr.size(), nw);
    for (int i = 0; i < nw && i < acc_addr.size(); i++) begin
      logic [31:0] ea;
      ea = addr + 32'(i * 4);
      chk($sformatf("addr[%0d]", i), acc_addr[i], ea);
      chk($sformatf("data[%0d]", i), acc_data[i], exp_data[i]);
    end
    chk("pops", pops, nw);
    chk("fifo_left", fifo_q.size(), extra);
    chk("protocol_viol", viol, 0);
    chk("gap_activity", gap_writes, 0);
    if (nw > 0) chk("done_after_last_accept", done_cyc - last_acc_cyc, 2);
    else chk("done_after_start", done_cyc - start_cyc, 2);
    stall_left = 0; gap_left = 0; mid_start = 1'b0;
  endtask
  initial begin
    iReset = 1'b1; iStart = 1'b0; iStartaddress = '0; iLength = '0;
    iFifo_empty = 1'b1; iFifo_data = '0; iWaitrequest = 1'b0;
    pend_pop = 1'b0; gap_now = 1'b0; mid_start = 1'b0;
    clear_stats();
    tick();
    tick();
    chk("rst_write", oWrite, 0);
    chk("rst_addr", oAddress, 0);
    chk("rst_data", oWritedata, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_done", oDone, 0);
    chk("rst_rdreq", oFifo_rdreq, 0);
    chk("byteenable", oByteenable, 4'hF);
    iReset = 1'b0;
    tick();
    run_xfer(32'h0000_1000, 32'd12, 2);
    stall_idx = 1; stall_left = 3;
    run_xfer(32'h0000_2000, 32'd16, 1);
    chk("stall_hold_cycles", acc_len.size() > 1 ? acc_len[1] : 0, 4);
    stall_idx = -1;
    gap_idx = 1; gap_left = 5;
    run_xfer(32'h0000_3000, 32'd16, 1);
    gap_idx = -1;
    run_xfer(32'h0000_4000, 32'd0, 1);
    run_xfer(32'h0000_5000, 32'd7, 1);
    mid_start = 1'b1;
    run_xfer(32'hFFFF_FFFC, 32'd8, 1);
    clear_stats();
    load_fifo(3);
    wait_pct = 100;
    iStart = 1'b1; iStartaddress = 32'h0000_7000; iLength = 32'd12;
    for (int k = 0; k < 50 && !oWrite; k++) tick();
    chk("write_before_reset", oWrite, 1);
    iReset = 1'b1;
    tick();
    iReset = 1'b0;
    chk("midrst_write", oWrite, 0);
    chk("midrst_addr", oAddress, 0);
    chk("midrst_data", oWritedata, 0);
    chk("midrst_busy", oBusy, 0);
    chk("midrst_rdreq", oFifo_rdreq, 0);
    wait_pct = 0;
    repeat (5) tick();
    chk("midrst_no_done", done_cnt, 0);
    run_xfer(32'h0000_6000, 32'd20, 0);
    iReset = 1'b1; iStart = 1'b1; iStartaddress = 32'h0000_1234; iLength = 32'd16;
    tick();
    iReset = 1'b0;
    chk("rst_prio_busy", oBusy, 0);
    chk("rst_prio_addr", oAddress, 0);
    repeat (4) tick();
    chk("rst_prio_idle", oBusy, 0);
    wait_pct = 30; gap_pct = 30;
    for (int t = 0; t < 6; t++)
      run_xfer($urandom & 32'hFFFF_FFFC, 32'($urandom_range(0, 40)), $urandom_range(0, 2));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
